eight_digit_scroller_core: RTL and testbench

Drives the board's 8-digit multiplexed seven-segment display with an 8-character window that scrolls continuously over a 16-digit circular hex message. Pressing the centre button appends the four hex digits on `SW[15:0]` to the message. Top-level board block: it is fed directly by the 100 MHz clock, the reset button, the switches and the centre button, and drives the cathode and anode pins.

---
 rtl/eight_digit_scroller_core.sv | 159 +++++++++++++++
 tb/tb_eight_digit_scroller_core.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/eight_digit_scroller_core.sv
// Eight-digit multiplexed seven-segment scroller over a 16-nibble circular hex message.
// Optional macro BTNC_DEBOUNCE_EN inserts a stability filter on the centre button.
module eight_digit_scroller_core #(
  parameter int REFRESH_DIV     = 100000,
  parameter int SCROLL_DIV      = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [15:0] SW,
  input  logic        BTNC,
  output logic [7:0]  SSEG,
  output logic [7:0]  AN
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  function automatic logic [7:0] enc(input logic [3:0] d);
    case (d)
      4'h0: enc = 8'hC0;
      4'h1: enc = 8'hF9;
      4'h2: enc = 8'hA4;
      4'h3: enc = 8'hB0;
      4'h4: enc = 8'h99;
      4'h5: enc = 8'h92;
      4'h6: enc = 8'h82;
      4'h7: enc = 8'hF8;
      4'h8: enc = 8'h80;
      4'h9: enc = 8'h90;
      4'hA: enc = 8'h88;
      4'hB: enc = 8'h83;
      4'hC: enc = 8'hC6;
      4'hD: enc = 8'hA1;
      4'hE: enc = 8'h86;
      4'hF: enc = 8'h8E;
      default: enc = 8'hFF;
    endcase
  endfunction

  logic [RW-1:0] refresh_cnt;
  logic [CW-1:0] scroll_cnt;
  logic [2:0]    scan_idx;
  logic [3:0]    off;
  logic [3:0]    msg [16];
  logic [3:0]    digit_idx;
  logic          refresh_wrap;
  logic          scroll_wrap;
  logic          btn_meta;
  logic          btn_sync;
  logic          btn_level;
  logic          btn_prev;
  logic          load;

  assign refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign scroll_wrap  = (scroll_cnt == CW'(SCROLL_DIV - 1));
  // Position 0 is the rightmost digit, so it shows the last character of the window.
  assign digit_idx    = off + 4'd7 - {1'b0, scan_idx};

  // Digit scan timebase and scan index.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      refresh_cnt <= '0;
      scan_idx    <= 3'd0;
    end else if (refresh_wrap) begin
      refresh_cnt <= '0;
      scan_idx    <= scan_idx + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Scroll timebase and window offset.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      scroll_cnt <= '0;
      off        <= 4'd0;
    end else if (scroll_wrap) begin
      scroll_cnt <= '0;
      off        <= off + 4'd1;
    end else begin
      scroll_cnt <= scroll_cnt + CW'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= BTNC;
      btn_sync <= btn_meta;
    end
  end

`ifdef BTNC_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [DW-1:0] db_cnt;
  logic          db_level;

  // Accept a new level only after it has held for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (btn_sync == db_level) begin
      db_cnt   <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt   <= '0;
      db_level <= btn_sync;
    end else begin
      db_cnt   <= db_cnt + DW'(1);
    end
  end

  assign btn_level = db_level;
`else
  assign btn_level = btn_sync;
`endif

  // Rising-edge detector producing a registered one-cycle load pulse.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      btn_prev <= 1'b0;
      load     <= 1'b0;
    end else begin
      btn_prev <= btn_level;
      load     <= btn_level & ~btn_prev;
    end
  end

  // Message buffer: shift left by four nibbles and append the switch digits.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < 16; i++) msg[i] <= 4'(i);
    end else if (load) begin
      for (int i = 0; i < 12; i++) msg[i] <= msg[i+4];
      msg[12] <= SW[15:12];
      msg[13] <= SW[11:8];
      msg[14] <= SW[7:4];
      msg[15] <= SW[3:0];
    end else begin
      for (int i = 0; i < 16; i++) msg[i] <= msg[i];
    end
  end

  // Registered anode and cathode drive.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      AN   <= 8'hFF;
      SSEG <= 8'hFF;
    end else begin
      AN   <= ~(8'd1 << scan_idx);
      SSEG <= enc(msg[digit_idx]);
    end
  end

endmodule

// File: tb/tb_eight_digit_scroller_core.sv
// Scoreboard bench for eight_digit_scroller_core: every cycle's AN/SSEG is predicted from
// a cycle-count model of scan, scroll and append behaviour, then compared at the falling edge.
module tb_eight_digit_scroller_core;

  localparam int RD = 2;
  localparam int SD = 64;
  localparam int DC = 8;
`ifdef BTNC_DEBOUNCE_EN
  localparam int LAT   = 4 + DC;
  localparam int PRESS = 12;
`else
  localparam int LAT   = 4;
  localparam int PRESS = 6;
`endif

  localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sw;
  logic        btnc;
  logic [7:0]  sseg;
  logic [7:0]  an;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [3:0]  m_cur [16];
  logic [3:0]  m_new [16];
  bit          pend;
  int          pend_at;
  logic [15:0] exp_q [$];

  eight_digit_scroller_core #(
    .REFRESH_DIV(RD),
    .SCROLL_DIV(SD),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .CLK100MHZ(clk),
    .CPU_RESETN(rst_n),
    .SW(sw),
    .BTNC(btnc),
    .SSEG(sseg),
    .AN(an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  // Expected {AN,SSEG} after active edge n: reflects state left by edge n-1.
  function automatic logic [15:0] exp_out(input int n);
    int m, s, o, idx;
    logic [3:0] d;
    logic [7:0] a;
    if (n == 0) return 16'hFFFF;
    m   = n - 1;
    s   = (m / RD) % 8;
    o   = (m / SD) % 16;
    idx = (o + 7 - s) % 16;
    d   = (pend && m >= pend_at) ? m_new[idx] : m_cur[idx];
    a   = ~(8'd1 << s);
    return {a, SEG[d]};
  endfunction

  task automatic compare(input logic [15:0] e, input string tag);
    n_assert++;
    assert (an === e[15:8]) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d AN got %h expected %h", tag, cyc, an, e[15:8]);
    end
    n_assert++;
    assert (sseg === e[7:0]) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d SSEG got %h expected %h", tag, cyc, sseg, e[7:0]);
    end
  endtask

  task automatic run_check(input int n, input string tag);
    logic [15:0] e;
    for (int i = 1; i <= n; i++) exp_q.push_back(exp_out(cyc + i));
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      compare(e, tag);
    end
  endtask

  task automatic check_now(input logic [15:0] v, input string tag);
    exp_q.push_back(v);
    compare(exp_q.pop_front(), tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_cur[i] = 4'(i);
    pend = 1'b0;
  endtask

  // Press for 'width' cycles; the model expects exactly one append.
  task automatic press(input logic [15:0] v, input int width, input string tag);
    for (int i = 0; i < 12; i++) m_new[i] = m_cur[i+4];
    m_new[12] = v[15:12];
    m_new[13] = v[11:8];
    m_new[14] = v[7:4];
    m_new[15] = v[3:0];
    pend    = 1'b1;
    pend_at = cyc + LAT;
    sw      = v;
    btnc    = 1'b1;
    run_check(width, tag);
    btnc    = 1'b0;
    run_check(LAT + 2, tag);
    for (int i = 0; i < 16; i++) m_cur[i] = m_new[i];
    pend = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    sw    = 16'h0000;
    btnc  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_now(16'hFFFF, "reset_hold");

    rst_n = 1'b1;
    run_check(16, "first_scan");
    run_check(60, "scroll_step");

    press(16'h0000, PRESS, "append_zero");
    run_check(32, "after_append");

    press(16'h1234, 200, "hold_press");
    press(16'hA5C3, PRESS, "second_press");
    run_check(16, "after_second");

    n = 1100 - cyc;
    run_check(n, "offset_wrap");

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now(16'hFFFF, "async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_now(16'hFFFF, "reset_held");
    rst_n = 1'b1;
    run_check(20, "post_reset");

`ifdef BTNC_DEBOUNCE_EN
    sw   = 16'h5A5A;
    btnc = 1'b1;
    run_check(5, "glitch");
    btnc = 1'b0;
    run_check(DC + 6, "glitch_ignored");
    press(16'hBEEF, 12, "debounced_press");
    run_check(16, "after_debounce");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
